// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle CPU control FSM with retired-instruction counter
//
// Purpose: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK for a small RV32-like
// instruction subset and counts retired instructions. All control outputs are
// decoded combinationally from the current state, the instruction, mem_ready and zero.
//
// Ports:
//   clk          - clock, rising-edge active
//   reset        - asynchronous active-high reset
//   instruction  - IR contents, stable from DECODE until back in FETCH
//   mem_ready    - memory completes the current access this cycle
//   zero         - ALU result equals 0 (branch condition)
//   mem_req      - memory access request
//   mem_write    - current access is a write
//   ir_write     - load IR from memory data
//   pc_write     - update PC
//   pc_src       - 0 = PC+4, 1 = ALU/branch target
//   reg_write    - register-file write enable
//   memtoreg     - write-back data from memory (1) or ALU (0)
//   alusrc       - ALU operand B is immediate (1) or rs2 (0)
//   alu_opcode   - 000 AND, 001 OR, 010 ADD, 011 SUB, 100 MUL, 101 SLL
//   busy         - high in every state except IDLE
//   instret      - retired-instruction counter (wraps)
module multicycle_controller #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int NUM_ALU_OPS       = 6
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [INSTRUCTION_WIDTH-1:0]   instruction,
  input  logic                           mem_ready,
  input  logic                           zero,
  output logic                           mem_req,
  output logic                           mem_write,
  output logic                           ir_write,
  output logic                           pc_write,
  output logic                           pc_src,
  output logic                           reg_write,
  output logic                           memtoreg,
  output logic                           alusrc,
  output logic [$clog2(NUM_ALU_OPS)-1:0] alu_opcode,
  output logic                           busy,
  output logic [31:0]                    instret
);

  localparam int AW = $clog2(NUM_ALU_OPS);

  localparam logic [AW-1:0] ALU_AND = AW'(0);
  localparam logic [AW-1:0] ALU_OR  = AW'(1);
  localparam logic [AW-1:0] ALU_ADD = AW'(2);
  localparam logic [AW-1:0] ALU_SUB = AW'(3);
  localparam logic [AW-1:0] ALU_MUL = AW'(4);
  localparam logic [AW-1:0] ALU_SLL = AW'(5);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEM       = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [31:0] r_instret;
  logic        w_retire;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic        w_is_r, w_is_i, w_is_load, w_is_store, w_is_branch, w_is_jump, w_legal;
  logic        w_unused_instr;

  assign w_opcode = instruction[6:0];
  assign w_funct3 = instruction[14:12];

  // Only a handful of instruction bits steer control; fold the rest away.
  assign w_unused_instr = ^instruction;

  assign w_is_r      = (w_opcode == 7'b0110011);
  assign w_is_i      = (w_opcode == 7'b0010011);
  assign w_is_load   = (w_opcode == 7'b0000011);
  assign w_is_store  = (w_opcode == 7'b0100011);
  assign w_is_branch = (w_opcode == 7'b1100011);
  // JAL (1101111) and JALR (1100111) share the 110?111 pattern.
  assign w_is_jump   = (w_opcode[6:4] == 3'b110) && (w_opcode[2:0] == 3'b111);
  assign w_legal     = w_is_r | w_is_i | w_is_load | w_is_store | w_is_branch | w_is_jump;

  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_write    = 1'b0;
    memtoreg     = 1'b0;
    alusrc       = 1'b0;
    alu_opcode   = ALU_ADD;
    case (r_state)
      S_IDLE: w_next_state = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      // Illegal opcodes fall back to FETCH as a NOP and never retire.
      S_DECODE: w_next_state = w_legal ? S_EXECUTE : S_FETCH;
      S_EXECUTE: begin
        w_next_state = S_WRITEBACK;
        if (w_is_r) begin
          case (w_funct3)
            3'b000:  alu_opcode = instruction[25] ? ALU_MUL :
                                  (instruction[30] ? ALU_SUB : ALU_ADD);
            3'b110:  alu_opcode = ALU_OR;
            default: alu_opcode = ALU_AND;
          endcase
        end else if (w_is_i) begin
          alusrc     = 1'b1;
          alu_opcode = (w_funct3 == 3'b001) ? ALU_SLL : ALU_ADD;
        end else if (w_is_load || w_is_store) begin
          alusrc       = 1'b1;
          w_next_state = S_MEM;
        end else if (w_is_branch) begin
          // BEQ: the SUB result drives zero, which redirects the PC this cycle.
          alu_opcode   = ALU_SUB;
          pc_write     = zero;
          pc_src       = zero;
          w_next_state = S_FETCH;
          w_retire     = 1'b1;
        end else if (w_is_jump) begin
          alusrc = 1'b1;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_write = w_is_store;
        if (mem_ready) begin
          w_next_state = w_is_store ? S_FETCH : S_WRITEBACK;
          w_retire     = w_is_store;
        end
      end
      S_WRITEBACK: begin
        reg_write    = 1'b1;
        memtoreg     = w_is_load;
        pc_write     = w_is_jump;
        pc_src       = w_is_jump;
        w_next_state = S_FETCH;
        w_retire     = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign busy    = (r_state != S_IDLE);
  assign instret = r_instret;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_instret <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (w_retire) r_instret <= r_instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        zero;
  logic        mem_req, mem_write, ir_write, pc_write, pc_src;
  logic        reg_write, memtoreg, alusrc, busy;
  logic [2:0]  alu_opcode;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_controller #(.INSTRUCTION_WIDTH(32), .NUM_ALU_OPS(6)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .memtoreg(memtoreg), .alusrc(alusrc),
    .alu_opcode(alu_opcode), .busy(busy), .instret(instret)
  );

  localparam int PH_IDLE = 0, PH_F = 1, PH_D = 2, PH_E = 3, PH_M = 4, PH_W = 5;
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JMP = 5, C_ILL = 6;
  localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b011, A_MUL = 3'b100, A_SLL = 3'b101;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_instret;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic int classify(input logic [31:0] ins);
    case (ins[6:0])
      7'h33:        return C_R;
      7'h13:        return C_I;
      7'h03:        return C_LD;
      7'h23:        return C_ST;
      7'h63:        return C_BR;
      7'h67, 7'h6F: return C_JMP;
      default:      return C_ILL;
    endcase
  endfunction

  function automatic logic [31:0] gen_instr(input int cls);
    logic [31:0] ins;
    ins = $urandom;
    case (cls)
      C_R:     ins[6:0] = 7'h33;
      C_I:     ins[6:0] = 7'h13;
      C_LD:    ins[6:0] = 7'h03;
      C_ST:    ins[6:0] = 7'h23;
      C_BR:    ins[6:0] = 7'h63;
      C_JMP:   ins[6:0] = rb() ? 7'h67 : 7'h6F;
      default: while (classify(ins) != C_ILL) ins[6:0] = 7'($urandom);
    endcase
    return ins;
  endfunction

  // Expected control word for one cycle, derived from the instruction class
  // and the phase the instruction is in.
  function automatic logic [11:0] model(input int ph, input int cls, input logic [31:0] ins,
                                        input bit rdy, input bit z);
    logic       mr, mw, irw, pcw, pcs, rw, m2r, asrc;
    logic [2:0] op;
    logic [2:0] f3;
    mr = 0; mw = 0; irw = 0; pcw = 0; pcs = 0; rw = 0; m2r = 0; asrc = 0;
    op = A_ADD;
    f3 = ins[14:12];
    case (ph)
      PH_F: begin mr = 1; irw = rdy; pcw = rdy; end
      PH_E: begin
        case (cls)
          C_R: begin
            if (f3 == 3'd0)      op = ins[25] ? A_MUL : (ins[30] ? A_SUB : A_ADD);
            else if (f3 == 3'd6) op = A_OR;
            else                 op = A_AND;
          end
          C_I:               begin asrc = 1; op = (f3 == 3'd1) ? A_SLL : A_ADD; end
          C_LD, C_ST, C_JMP: asrc = 1;
          C_BR:              begin op = A_SUB; pcw = z; pcs = z; end
          default: ;
        endcase
      end
      PH_M: begin mr = 1; mw = (cls == C_ST); end
      PH_W: begin rw = 1; m2r = (cls == C_LD); pcw = (cls == C_JMP); pcs = (cls == C_JMP); end
      default: ;
    endcase
    return {mr, mw, irw, pcw, pcs, rw, m2r, asrc, op, (ph != PH_IDLE)};
  endfunction

  function automatic logic [11:0] observed();
    return {mem_req, mem_write, ir_write, pc_write, pc_src, reg_write, memtoreg, alusrc,
            alu_opcode, busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of an instruction: drive inputs, check at the falling edge, advance.
  task automatic cyc(input int ph, input int cls, input logic [31:0] ins,
                     input bit rdy, input bit z, input bit ret);
    mem_ready = rdy;
    zero      = z;
    @(negedge clk);
    chk($sformatf("ctrl ph%0d ins=%h", ph, ins), {20'd0, observed()},
        {20'd0, model(ph, cls, ins, rdy, z)});
    chk($sformatf("instret ph%0d ins=%h", ph, ins), instret, m_instret);
    @(posedge clk);
    #1;
    if (ret) m_instret = m_instret + 32'd1;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input bit zb);
    int cls;
    cls = classify(ins);
    instruction = $urandom;
    for (int i = 0; i <= fw; i++) cyc(PH_F, cls, ins, (i == fw), rb(), 1'b0);
    instruction = ins;
    cyc(PH_D, cls, ins, rb(), rb(), 1'b0);
    if (cls == C_ILL) return;
    cyc(PH_E, cls, ins, rb(), (cls == C_BR) ? zb : rb(), (cls == C_BR));
    if (cls == C_BR) return;
    if (cls == C_LD || cls == C_ST)
      for (int i = 0; i <= mw; i++) cyc(PH_M, cls, ins, (i == mw), rb(), (cls == C_ST) && (i == mw));
    if (cls == C_ST) return;
    cyc(PH_W, cls, ins, rb(), rb(), 1'b1);
  endtask

  task automatic idle_cycle();
    mem_ready = rb();
    zero      = rb();
    @(negedge clk);
    chk("idle ctrl", {20'd0, observed()}, {20'd0, model(PH_IDLE, C_ILL, 32'd0, 1'b0, 1'b0)});
    chk("idle instret", instret, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    mem_ready   = 1'b0;
    zero        = 1'b0;
    instruction = 32'd0;
    m_instret   = 32'd0;

    @(negedge clk);
    chk("reset ctrl", {20'd0, observed()}, 32'h004);
    chk("reset instret", instret, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_cycle();

    // Directed instructions.
    run_instr(32'h002081B3, 0, 0, 1'b0);               // add x3,x1,x2
    chk("add retired", instret, 32'd1);
    run_instr(32'h402081B3, 0, 0, 1'b0);               // sub
    run_instr(32'h022081B3, 1, 0, 1'b0);               // mul
    run_instr(32'h0020E1B3, 0, 0, 1'b0);               // or
    run_instr(32'h0020F1B3, 0, 0, 1'b0);               // and
    run_instr(32'h0000A183, 2, 2, 1'b0);               // lw, 9 cycles
    run_instr(32'h00208063, 0, 0, 1'b1);               // beq taken
    run_instr(32'h00208063, 0, 0, 1'b0);               // beq not taken
    run_instr(32'h0000007F, 0, 0, 1'b0);               // illegal opcode
    run_instr(32'h0020A023, 0, 1, 1'b0);               // sw
    run_instr(32'h0000006F, 0, 0, 1'b0);               // jal
    run_instr(32'h000080E7, 0, 0, 1'b0);               // jalr
    run_instr(32'h00109093, 0, 0, 1'b0);               // slli
    run_instr(32'h00108093, 0, 0, 1'b0);               // addi

    // Randomized instruction stream with random memory wait states.
    for (int n = 0; n < 60; n++)
      run_instr(gen_instr($urandom_range(0, 6)), $urandom_range(0, 2), $urandom_range(0, 2), rb());

    // Reset in the middle of a stalled store: mem_req must drop at once.
    instruction = 32'h0020A023;
    cyc(PH_F, C_ST, 32'h0020A023, 1'b1, rb(), 1'b0);
    cyc(PH_D, C_ST, 32'h0020A023, rb(), rb(), 1'b0);
    cyc(PH_E, C_ST, 32'h0020A023, rb(), rb(), 1'b0);
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw mem stalled", {20'd0, observed()}, {20'd0, model(PH_M, C_ST, 32'h0020A023, 1'b0, zero)});
    #1;
    reset     = 1'b1;
    mem_ready = 1'b1;
    #1;
    m_instret = 32'd0;
    chk("async reset ctrl", {20'd0, observed()}, 32'h004);
    chk("async reset instret", instret, 32'd0);
    @(posedge clk);
    #1;
    chk("reset held ctrl", {20'd0, observed()}, 32'h004);
    chk("reset held instret", instret, 32'd0);
    reset = 1'b0;
    idle_cycle();
    run_instr(32'h0020A023, 0, 0, 1'b0);
    chk("post-reset sw retired", instret, 32'd1);

    // Counter wrap.
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    m_instret = 32'hFFFF_FFFF;
    run_instr(32'h002081B3, 0, 0, 1'b0);
    chk("instret wrap", instret, 32'd0);
    run_instr(gen_instr(C_R), 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
